// File: rtl/arf132b192e1r1w0cbbehcaa4acw_wr_arb.sv
// Round-robin write-port arbiter for the 192x132 latch register file.
// One-stage registered write pipe with out-of-range drop and read bypass.
module arf132b192e1r1w0cbbehcaa4acw_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ENTRIES = 192,
  parameter int AW      = 8,
  parameter int DW      = 132
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_rdy,
  input  logic                 wr_hold,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_byp,
  output logic [DW-1:0]        rd_byp_data,
  output logic                 err_oor,
  output logic [2:0]           err_id
);

  logic [2:0]    ptr;
  logic [2:0]    ptr_nxt;
  logic [2:0]    gnt_id;
  logic [2:0]    idx;
  logic [3:0]    sum;
  logic [7:0]    vld8;
  logic          found;
  logic          grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          in_range;

  assign vld8 = 8'(req_vld);

  // Search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = 3'd0;
    sum    = 4'd0;
    idx    = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(NUM_REQ)) begin
        sum = sum - 4'(NUM_REQ);
      end
      idx = sum[2:0];
      if (!found && vld8[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign grant = found & ~wr_hold & rst_b;

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = grant & (gnt_id == 3'(i));
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == 3'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign in_range = ({1'b0, sel_addr} < (AW+1)'(ENTRIES));

  assign ptr_nxt = (gnt_id == 3'(NUM_REQ-1)) ? 3'd0 : gnt_id + 3'd1;

  // Address/data only load on an accepted in-range write to avoid toggling.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr     <= 3'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err_oor <= 1'b0;
      err_id  <= 3'd0;
    end else begin
      wr_en   <= 1'b0;
      err_oor <= 1'b0;
      if (grant) begin
        ptr <= ptr_nxt;
        if (in_range) begin
          wr_en   <= 1'b1;
          wr_addr <= sel_addr;
          wr_data <= sel_data;
        end else begin
          err_oor <= 1'b1;
          err_id  <= gnt_id;
        end
      end
    end
  end

  // Latch write is not visible until the low phase ends, so forward it.
  assign rd_byp      = rd_en & wr_en & (rd_addr == wr_addr);
  assign rd_byp_data = wr_data;

endmodule

// File: doc/arf132b192e1r1w0cbbehcaa4acw_wr_arb.md
Name: arf132b192e1r1w0cbbehcaa4acw_wr_arb

Overview:
- Shares the single write port of the 192-entry x 132-bit latch-based 1R1W register file among NUM_REQ requesters using round-robin arbitration.
- Registers the granted write into a one-stage array write pipe. The write latches are transparent during the clock-low phase.
- Rejects out-of-range addresses.
- Flags read-after-write collisions with the in-flight write and supplies bypass data for them.
- Sits between the requester logic and the array write-port pins.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- ENTRIES, 192, number of valid array entries.
- AW, 8, address width.
- DW, 132, data width.

Ports:
- clk  input  1  array clock. The array latches use its inverse.
- rst_b  input  1  asynchronous active-low reset.
- req_vld  input  NUM_REQ  per-requester write valid.
- req_addr  input  NUM_REQ*AW  per-requester write address. Requester i uses slice [i*AW +: AW].
- req_data  input  NUM_REQ*DW  per-requester write data. Requester i uses slice [i*DW +: DW].
- req_rdy  output  NUM_REQ  one-hot grant. A transfer occurs when req_vld[i] and req_rdy[i] are both 1.
- wr_hold  input  1  array-side stall. While it is 1, no grant is issued.
- wr_en  output  1  registered array write enable.
- wr_addr  output  AW  registered array write address.
- wr_data  output  DW  registered array write data.
- rd_en  input  1  array read enable, same cycle as rd_addr.
- rd_addr  input  AW  array read address.
- rd_byp  output  1  the read hits the in-flight write. The consumer must use rd_byp_data.
- rd_byp_data  output  DW  the value of wr_data.
- err_oor  output  1  one-cycle pulse: an out-of-range write was accepted and dropped.
- err_id  output  3  requester index of the last out-of-range write.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0, err_oor=0, err_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - req_rdy=0 while in reset.
- Grant (combinational, same cycle):
  - When wr_hold=0, req_rdy is one-hot on the first requester with req_vld=1, searching upward from the pointer with wrap.
  - When wr_hold=1 or no requester is valid, req_rdy=0.
  - req_rdy must not depend on req_addr or req_data.
- Pointer update: on a transfer by requester g, the pointer becomes (g+1) mod NUM_REQ. With no transfer, the pointer holds.
- Write pipe, one cycle latency:
  - On a transfer with addr < ENTRIES: next cycle wr_en=1, and wr_addr/wr_data carry the granted values.
  - On a transfer with addr >= ENTRIES: next cycle wr_en=0, err_oor=1, err_id=g.
  - With no transfer: wr_en=0 next cycle, and wr_addr/wr_data hold their values (no toggle, for power).
- Back-to-back: a new grant is allowed every cycle. The pipe never stalls once a transfer has been accepted.
- wr_hold affects only new grants. A write already registered in the pipe still drives wr_en in the following cycle.
- Read bypass:
  - rd_byp = rd_en & wr_en & (rd_addr == wr_addr), combinational.
  - rd_byp_data = wr_data at all times.
  - Reason: the array write is not visible through the latch before the end of the low phase.
- Two requesters targeting the same address in consecutive cycles: both writes are issued in grant order. Last writer wins.
- Reset asserted mid-stream: any in-flight write is discarded (wr_en forced to 0 immediately). No partial write is issued after rst_b deasserts.
- Release: after rst_b deasserts, the first grant may occur on the first rising edge.

Test Plan:
- All 4 requesters valid continuously, wr_hold=0, addresses 10/20/30/40 -> grants in order 0,1,2,3,0,...; wr_en=1 every cycle from cycle 2; wr_addr follows the sequence 10,20,30,40.
- Only requester 2 valid, addr 191, data 132'h5A... -> req_rdy=4'b0100 in the same cycle; next cycle wr_en=1, wr_addr=191; pointer becomes 3.
- Requester 1 valid, addr 192 -> req_rdy[1]=1; next cycle wr_en=0, err_oor=1 for one cycle, err_id=1.
- wr_hold=1 for 3 cycles with requesters 0 and 3 valid -> req_rdy=0 throughout. The pending pipe write (addr 7) still issues in the first hold cycle. After hold drops, requester 0 is granted with pointer=0.
- wr_en=1, wr_addr=55, wr_data=D; rd_en=1, rd_addr=55 -> rd_byp=1, rd_byp_data=D. With rd_addr=56 -> rd_byp=0.
- rst_b pulsed low while wr_en=1 -> wr_en=0 asynchronously and pointer=0. After release, the first grant goes to the lowest valid requester.
